// File: rtl/keypad_if.sv
// keypad_if: keypad-side pins and debounced key outputs of the scanner.
// master = scanner, slave = keypad/consumer side.
interface keypad_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [7:0] key_coord;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  row_in,
      output col_out, key_coord, key_valid, key_held
   );

   modport slave (
      output row_in,
      input  col_out, key_coord, key_valid, key_held
   );
endinterface

// File: rtl/keypad_scan_unit.sv
// keypad_scan_unit: 4x4 active-low keypad scanner with press/release debounce.
// Define KEYPAD_AUTO_REPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scan_unit #(
   parameter int SCAN_DIV     = 100_000,
   parameter int DEBOUNCE_CNT = 20,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic     clk,
   input  logic     rst,
   keypad_if.master kp
);
   localparam int DW = $clog2(SCAN_DIV + 1);
   localparam int MW = $clog2(DEBOUNCE_CNT + 1);

   if (SCAN_DIV < 2) begin : g_bad_div
      $error("SCAN_DIV must be >= 2");
   end
   if (DEBOUNCE_CNT < 1) begin : g_bad_deb
      $error("DEBOUNCE_CNT must be >= 1");
   end
   if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
      $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    rs1, rs;
   logic [DW-1:0] dwell;
   logic [3:0]    col_q, col_nxt, col_rot;
   logic [7:0]    cand, cand_nxt;
   logic [7:0]    coord_q, coord_nxt;
   logic [7:0]    here;
   logic [MW-1:0] match_cnt, match_nxt, match_inc;
   logic [MW-1:0] rel_cnt, rel_nxt, rel_inc;
   logic          valid_q, valid_nxt;
   logic          held_q, held_nxt;
   logic          sample, one_low, enter_held;
   logic          rep_fire;

   assign sample  = (dwell == DW'(SCAN_DIV - 1));
   assign one_low = $onehot(~rs);
   assign here    = {~col_q, ~rs};
   assign col_rot = {col_q[2:0], col_q[3]};

   assign match_inc = (match_cnt == MW'(DEBOUNCE_CNT)) ?
                      match_cnt : match_cnt + MW'(1);
   assign rel_inc   = (rel_cnt == MW'(DEBOUNCE_CNT)) ?
                      rel_cnt : rel_cnt + MW'(1);

`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rep_cnt, rep_nxt, rep_inc, rep_target;
   logic          rep_armed, rep_armed_nxt;

   // First target is the initial delay, then the repeat period.
   always_comb begin
      rep_nxt       = rep_cnt;
      rep_armed_nxt = rep_armed;
      rep_fire      = 1'b0;
      rep_inc       = rep_cnt + RW'(1);
      rep_target    = rep_armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
      if (state != HELD) begin
         rep_nxt       = '0;
         rep_armed_nxt = 1'b0;
      end else if (sample) begin
         if (!one_low) begin
            rep_nxt       = '0;
            rep_armed_nxt = 1'b0;
         end else if (rep_inc == rep_target) begin
            rep_fire      = 1'b1;
            rep_nxt       = '0;
            rep_armed_nxt = 1'b1;
         end else begin
            rep_nxt = rep_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_armed <= 1'b0;
      end else begin
         rep_cnt   <= rep_nxt;
         rep_armed <= rep_armed_nxt;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      state_nxt  = state;
      col_nxt    = col_q;
      cand_nxt   = cand;
      match_nxt  = match_cnt;
      rel_nxt    = rel_cnt;
      coord_nxt  = coord_q;
      valid_nxt  = 1'b0;
      held_nxt   = held_q;
      enter_held = 1'b0;
      if (sample) begin
         unique case (state)
            SCAN: begin
               if (one_low) begin
                  cand_nxt   = here;
                  match_nxt  = MW'(1);
                  state_nxt  = DEBOUNCE;
                  enter_held = (DEBOUNCE_CNT == 1);
               end else begin
                  col_nxt = col_rot;
               end
            end
            DEBOUNCE: begin
               if (here == cand) begin
                  match_nxt  = match_inc;
                  enter_held = (match_inc == MW'(DEBOUNCE_CNT));
               end else begin
                  match_nxt = '0;
                  state_nxt = SCAN;
                  col_nxt   = col_rot;
               end
            end
            HELD: begin
               // Any row on the frozen column keeps the key alive.
               if (one_low) begin
                  rel_nxt = '0;
               end else if (rel_inc == MW'(DEBOUNCE_CNT)) begin
                  rel_nxt   = '0;
                  coord_nxt = '0;
                  held_nxt  = 1'b0;
                  state_nxt = SCAN;
                  col_nxt   = col_rot;
               end else begin
                  rel_nxt = rel_inc;
               end
            end
            default: state_nxt = SCAN;
         endcase
      end
      if (enter_held) begin
         coord_nxt = cand_nxt;
         valid_nxt = 1'b1;
         held_nxt  = 1'b1;
         state_nxt = HELD;
         match_nxt = '0;
         rel_nxt   = '0;
      end
      if (rep_fire) valid_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs1       <= 4'hF;
         rs        <= 4'hF;
         dwell     <= '0;
         state     <= SCAN;
         col_q     <= 4'b1110;
         cand      <= '0;
         match_cnt <= '0;
         rel_cnt   <= '0;
         coord_q   <= '0;
         valid_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         rs1       <= kp.row_in;
         rs        <= rs1;
         dwell     <= sample ? '0 : dwell + DW'(1);
         state     <= state_nxt;
         col_q     <= col_nxt;
         cand      <= cand_nxt;
         match_cnt <= match_nxt;
         rel_cnt   <= rel_nxt;
         coord_q   <= coord_nxt;
         valid_q   <= valid_nxt;
         held_q    <= held_nxt;
      end
   end

   assign kp.col_out   = col_q;
   assign kp.key_coord = coord_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_unit.sv
// tb_keypad_scan_unit: physical keypad stimulus, directed and random,
// checked every cycle against a sample-level model of the scanner.
module tb_keypad_scan_unit;
   localparam int SD = 4;
   localparam int DB = 3;
   localparam int RD = 4;
   localparam int RR = 2;
`ifdef KEYPAD_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif
   localparam int M_SCAN = 0;
   localparam int M_DEB  = 1;
   localparam int M_HELD = 2;
   localparam int K42    = 2 * 4 + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   keypad_if kif();

   keypad_scan_unit #(
      .SCAN_DIV    (SD),
      .DEBOUNCE_CNT(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp (kif)
   );

   int          checks = 0;
   int          failures = 0;
   logic [15:0] keys = '0;
   bit          use_raw = 1'b0;
   logic [3:0]  raw_rows = 4'hF;
   bit          rst_req = 1'b1;
   int          pulses = 0;
   int          col_moves = 0;
   logic [3:0]  prev_col = 4'b1110;

   int         m_col, m_mode, m_match, m_rel, m_rep, m_dwell;
   logic [7:0] m_cand, m_coord;
   bit         m_kv, m_held;
   logic [3:0] m_s1, m_rs;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] rows_for(input logic [3:0] cols,
                                           input logic [15:0] k);
      logic [3:0] r;
      r = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!cols[c])
            for (int i = 0; i < 4; i++)
               if (k[c*4+i]) r[i] = 1'b0;
      return r;
   endfunction

   function automatic logic [3:0] exp_col();
      return ~(4'(1 << m_col));
   endfunction

   task automatic model_reset();
      m_col = 0; m_mode = M_SCAN; m_match = 0; m_rel = 0;
      m_rep = 0; m_dwell = 0; m_cand = '0; m_coord = '0;
      m_kv = 1'b0; m_held = 1'b0; m_s1 = 4'hF; m_rs = 4'hF;
   endtask

   task automatic enter_held();
      m_coord = m_cand; m_kv = 1'b1; m_held = 1'b1;
      m_mode = M_HELD; m_rel = 0; m_rep = 0; m_match = 0;
   endtask

   // One clock edge: sample-level rules applied to the synchronised rows.
   task automatic model_edge(input logic [3:0] rin);
      int nlow, row;
      logic [7:0] here;
      bit smp;
      if (rst) begin
         model_reset();
         return;
      end
      smp = (m_dwell == SD - 1);
      m_kv = 1'b0;
      if (smp) begin
         nlow = 0; row = 0;
         for (int i = 0; i < 4; i++)
            if (!m_rs[i]) begin nlow++; row = i; end
         here = {4'(1 << m_col), 4'(1 << row)};
         if (m_mode == M_SCAN) begin
            if (nlow == 1) begin
               m_cand = here; m_match = 1;
               if (m_match >= DB) enter_held(); else m_mode = M_DEB;
            end else m_col = (m_col + 1) % 4;
         end else if (m_mode == M_DEB) begin
            if (nlow == 1 && here == m_cand) begin
               m_match++;
               if (m_match >= DB) enter_held();
            end else begin
               m_match = 0; m_mode = M_SCAN; m_col = (m_col + 1) % 4;
            end
         end else begin
            if (nlow != 1) begin
               m_rep = 0; m_rel++;
               if (m_rel >= DB) begin
                  m_coord = '0; m_held = 1'b0; m_mode = M_SCAN;
                  m_rel = 0; m_col = (m_col + 1) % 4;
               end
            end else begin
               m_rel = 0; m_rep++;
               if (REP && (m_rep == RD ||
                   (m_rep > RD && (m_rep - RD) % RR == 0)))
                  m_kv = 1'b1;
            end
         end
      end
      m_dwell = smp ? 0 : m_dwell + 1;
      m_rs = m_s1;
      m_s1 = rin;
   endtask

   task automatic step();
      @(negedge clk);
      rst = rst_req;
      kif.row_in = use_raw ? raw_rows : rows_for(kif.col_out, keys);
      if (rst) begin
         #1;
         model_reset();
         check("rst_col", kif.col_out, 4'b1110);
         check("rst_coord", kif.key_coord, 8'h00);
         check("rst_valid", kif.key_valid, 1'b0);
         check("rst_held", kif.key_held, 1'b0);
      end
      @(posedge clk);
      model_edge(kif.row_in);
      #1;
      check("col_out", kif.col_out, exp_col());
      check("key_coord", kif.key_coord, m_coord);
      check("key_valid", kif.key_valid, m_kv);
      check("key_held", kif.key_held, m_held);
      if (kif.key_valid === 1'b1) pulses++;
      if (kif.col_out !== prev_col) col_moves++;
      prev_col = kif.col_out;
   endtask

   task automatic run_until(input int mode, input int match,
                            input int budget, input string tag);
      int n;
      n = 0;
      while (!(m_mode == mode && (match < 0 || m_match == match)) &&
             n < budget) begin
         step();
         n++;
      end
      check(tag, (m_mode == mode), 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic [3:0] rot [4];
      int kind, len;
      rot = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
      kif.row_in = 4'hF;
      model_reset();
      rst_req = 1'b1;
      repeat (3) step();
      rst_req = 1'b0;

      for (int k = 0; k < 4; k++) begin
         repeat (SD) step();
         check("t1_rot", kif.col_out, rot[k]);
      end

      pulses = 0;
      keys = '0; keys[K42] = 1'b1;
      run_until(M_HELD, -1, 200, "t2_reach");
      repeat (2 * SD) step();
      check("t2_coord", kif.key_coord, 8'h42);
      check("t2_held", kif.key_held, 1'b1);
      check("t2_col", kif.col_out, 4'b1011);
      check("t2_pulses", pulses, 1);

      keys = '0;
      run_until(M_SCAN, -1, 100, "t4_reach");
      check("t4_coord", kif.key_coord, 8'h00);
      check("t4_held", kif.key_held, 1'b0);
      check("t4_col", kif.col_out, 4'b0111);

      keys[K42] = 1'b1;
      run_until(M_HELD, -1, 200, "t4b_reach");
      keys = '0;
      run_until(M_HELD, -1, 1, "t4b_stay");
      while (m_rel < 2 && m_mode == M_HELD) step();
      keys[K42] = 1'b1;
      repeat (3 * SD) step();
      check("t4b_held", kif.key_held, 1'b1);
      check("t4b_coord", kif.key_coord, 8'h42);
      keys = '0;
      run_until(M_SCAN, -1, 100, "t4b_rel");

      keys[K42] = 1'b1;
      run_until(M_DEB, 2, 200, "t3_reach");
      keys = '0;
      pulses = 0;
      run_until(M_SCAN, -1, 50, "t3_abort");
      check("t3_pulses", pulses, 0);
      check("t3_coord", kif.key_coord, 8'h00);
      check("t3_col", kif.col_out, 4'b0111);

      use_raw = 1'b1; raw_rows = 4'b1100;
      pulses = 0; col_moves = 0;
      repeat (8 * SD) step();
      check("t5_pulses", pulses, 0);
      check("t5_moves", col_moves, 8);
      use_raw = 1'b0;

      keys[K42] = 1'b1;
      run_until(M_DEB, 1, 200, "t6_reach");
      pulses = 0;
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      step();
      check("t6_nopulse", pulses, 0);
      run_until(M_HELD, -1, 200, "t6_repress");
      check("t6_coord", kif.key_coord, 8'h42);
      check("t6_pulses", pulses, 1);
      keys = '0;
      run_until(M_SCAN, -1, 100, "t6_rel");

      pulses = 0;
      keys[K42] = 1'b1;
      run_until(M_HELD, -1, 200, "t7_reach");
      repeat (10 * SD + 1) step();
      keys = '0;
      run_until(M_SCAN, -1, 100, "t7_rel");
      check("t7_pulses", pulses, REP ? 5 : 1);

      for (int it = 0; it < 80; it++) begin
         kind = $urandom_range(0, 5);
         len  = $urandom_range(1, 20 * SD);
         use_raw = 1'b0;
         keys = '0;
         case (kind)
            0, 5: keys[$urandom_range(0, 15)] = 1'b1;
            1: begin
               keys[$urandom_range(0, 15)] = 1'b1;
               keys[$urandom_range(0, 15)] = 1'b1;
            end
            2: use_raw = 1'b1;
            default: ;
         endcase
         for (int j = 0; j < len; j++) begin
            if (kind == 2) raw_rows = 4'($urandom);
            if (kind == 5 && $urandom_range(0, 7) == 0)
               keys = ~keys & (keys | 16'(1 << $urandom_range(0, 15)));
            step();
         end
         if (kind == 4) begin
            rst_req = 1'b1;
            step();
            rst_req = 1'b0;
         end
      end

      keys = '0;
      use_raw = 1'b0;
      repeat (8 * SD) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
